// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache controller: same-cycle hits, single-beat line refill.
// Optional hit/miss performance counters are enabled with `define ICACHE_PERF_CNT_EN.
module icache_ctrl #(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4,
    parameter int XLEN       = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req_i,
    input  logic [XLEN-1:0]         if_addr_i,
    input  logic                    if_kill_i,
    input  logic                    if_flush_i,
    output logic                    if_ack_o,
    output logic [31:0]             if_rdata_o,
    output logic                    mem_req_o,
    output logic [XLEN-1:0]         mem_addr_o,
    input  logic                    mem_ack_i,
    input  logic [32*LINE_WORDS-1:0] mem_rdata_i
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]             hit_cnt_o,
    output logic [31:0]             miss_cnt_o
`endif
);

    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int IDX_W   = $clog2(SETS);
    localparam int IDX_LSB = OFF_W + 2;
    localparam int TAG_LSB = IDX_LSB + IDX_W;
    localparam int TAG_W   = XLEN - TAG_LSB;
    localparam int LINE_W  = 32 * LINE_WORDS;

    typedef enum logic [1:0] {IDLE, MISS, KILLED, FLUSH} state_t;

    state_t             state_q, state_d;
    logic [SETS-1:0]    valid_q;
    logic [TAG_W-1:0]   tag_arr  [SETS];
    logic [LINE_W-1:0]  data_arr [SETS];
    logic [IDX_W-1:0]   flush_cnt_q;
    logic               flush_pend_q;

    logic [IDX_W-1:0]   req_idx, fill_idx;
    logic [TAG_W-1:0]   req_tag, fill_tag;
    logic [OFF_W-1:0]   req_off;
    logic [LINE_W-1:0]  req_line;
    logic               hit;
    logic               ack, miss_start, fill_en, flush_start, refill_done;
    logic               unused_addr_lsb;

    assign req_idx  = if_addr_i[TAG_LSB-1:IDX_LSB];
    assign req_tag  = if_addr_i[XLEN-1:TAG_LSB];
    assign req_off  = if_addr_i[IDX_LSB-1:2];
    assign fill_idx = mem_addr_o[TAG_LSB-1:IDX_LSB];
    assign fill_tag = mem_addr_o[XLEN-1:TAG_LSB];
    assign unused_addr_lsb = ^if_addr_i[1:0];

    assign req_line = data_arr[req_idx];
    assign hit      = if_req_i & valid_q[req_idx] & (tag_arr[req_idx] == req_tag);

    // Bus response that ends an outstanding refill (MISS or KILLED); ignored elsewhere.
    assign refill_done = mem_ack_i & ((state_q == MISS) | (state_q == KILLED));

    always_comb begin
        state_d     = state_q;
        ack         = 1'b0;
        miss_start  = 1'b0;
        fill_en     = 1'b0;
        flush_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_flush_i) begin
                    state_d     = FLUSH;
                    flush_start = 1'b1;
                end else if (hit) begin
                    ack = 1'b1;
                end else if (if_req_i && !if_kill_i) begin
                    miss_start = 1'b1;
                    state_d    = MISS;
                end
            end
            MISS: begin
                if (mem_ack_i) begin
                    if (flush_pend_q || if_flush_i) begin
                        state_d     = FLUSH;
                        flush_start = 1'b1;
                    end else begin
                        fill_en = 1'b1;
                        state_d = IDLE;
                    end
                end else if (if_kill_i) begin
                    state_d = KILLED;
                end
            end
            KILLED: begin
                if (mem_ack_i) begin
                    if (flush_pend_q || if_flush_i) begin
                        state_d     = FLUSH;
                        flush_start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (if_flush_i) begin
                    flush_start = 1'b1;
                end else if (flush_cnt_q == IDX_W'(SETS - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign if_ack_o   = ack & ~rst;
    assign if_rdata_o = if_ack_o ? req_line[{req_off, 5'b0} +: 32] : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
        end else if (miss_start) begin
            mem_req_o  <= 1'b1;
            mem_addr_o <= {if_addr_i[XLEN-1:IDX_LSB], {IDX_LSB{1'b0}}};
        end else if (refill_done) begin
            mem_req_o  <= 1'b0;
        end
    end

    // A flush seen while a refill is outstanding waits here until the bus transaction ends.
    always_ff @(posedge clk) begin
        if (rst)
            flush_pend_q <= 1'b0;
        else if (flush_start)
            flush_pend_q <= 1'b0;
        else if (if_flush_i && ((state_q == MISS) || (state_q == KILLED)))
            flush_pend_q <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)              flush_cnt_q <= '0;
        else if (flush_start) flush_cnt_q <= '0;
        else if (state_q == FLUSH) flush_cnt_q <= flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (state_q == FLUSH) begin
            valid_q[flush_cnt_q] <= 1'b0;
        end else if (fill_en) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_arr[fill_idx]  <= fill_tag;
            data_arr[fill_idx] <= mem_rdata_i;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            if (ack)        hit_cnt_o  <= hit_cnt_o + 32'd1;
            if (miss_start) miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl: directed scenarios plus randomized fetch traffic against a set/tag model.
module tb_icache_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         if_req_i, if_kill_i, if_flush_i, mem_ack_i;
    logic [31:0]  if_addr_i;
    logic         if_ack_o, mem_req_o;
    logic [31:0]  if_rdata_o, mem_addr_o;
    logic [127:0] mem_rdata_i;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]  hit_cnt_o, miss_cnt_o;
`endif

    int checks = 0;
    int errors = 0;
    int n_hit  = 0;
    int n_miss = 0;

    bit           m_valid [64];
    logic [31:0]  m_tag   [64];
    logic [127:0] m_data  [64];

    always #5 clk = ~clk;

    icache_ctrl #(.SETS(64), .LINE_WORDS(4), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_kill_i(if_kill_i), .if_flush_i(if_flush_i),
        .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
`ifdef ICACHE_PERF_CNT_EN
        , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
    );

    function automatic logic [127:0] mk_line(input logic [31:0] la);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) l[w*32 +: 32] = (la + 32'(w*4)) * 32'h9E3779B1 ^ 32'h5A5A1234;
        return l;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; if_req_i = 0; if_kill_i = 0; if_flush_i = 0; mem_ack_i = 0;
        if_addr_i = 0; mem_rdata_i = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        n_hit = 0; n_miss = 0;
    endtask

    // Called just after a negedge; returns just after a negedge with the cache idle.
    // killat < lat: kill while waiting (line dropped); killat == lat: kill with the ack (line kept).
    task automatic fetch(input logic [31:0] a, input int lat, input int killat, input logic [127:0] line);
        int s, w;
        bit hit;
        logic [31:0] exp_d;
        s = (a / 16) % 64;
        w = (a / 4) % 4;
        hit = m_valid[s] && (m_tag[s] == a / 1024);
        exp_d = hit ? m_data[s][w*32 +: 32] : 32'h0;
        if_req_i = 1'b1; if_addr_i = a;
        #1;
        checks++;
        if (if_ack_o !== hit || if_rdata_o !== exp_d) begin
            errors++;
            $display("FAIL fetch %h: ack/rdata got %b/%h exp %b/%h", a, if_ack_o, if_rdata_o, hit, exp_d);
        end
        @(negedge clk);
        if_req_i = 1'b0;
        if (hit) begin
            n_hit++;
        end else begin
            n_miss++;
            for (int c = 0; c <= lat; c++) begin
                #1;
                checks++;
                if (mem_req_o !== 1'b1 || mem_addr_o !== (a & ~32'hF) || if_ack_o !== 1'b0) begin
                    errors++;
                    $display("FAIL refill %h cyc %0d: req/addr/ack got %b/%h/%b exp 1/%h/0",
                             a, c, mem_req_o, mem_addr_o, if_ack_o, a & ~32'hF);
                end
                if (c == killat) if_kill_i = 1'b1;
                if (c == lat) begin mem_ack_i = 1'b1; mem_rdata_i = line; end
                else mem_rdata_i = {$urandom, $urandom, $urandom, $urandom};
                @(negedge clk);
                if_kill_i = 1'b0; mem_ack_i = 1'b0;
            end
            #1;
            checks++;
            if (mem_req_o !== 1'b0) begin
                errors++;
                $display("FAIL req_drop %h: mem_req got %b exp 0", a, mem_req_o);
            end
            if (killat >= lat) begin
                m_valid[s] = 1'b1; m_tag[s] = a / 1024; m_data[s] = line;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (if_ack_o !== 1'b0 || if_rdata_o !== 32'h0 || mem_req_o !== 1'b0 || mem_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL reset: ack/rdata/req/addr got %b/%h/%b/%h exp 0/0/0/0",
                     if_ack_o, if_rdata_o, mem_req_o, mem_addr_o);
        end
`ifdef ICACHE_PERF_CNT_EN
        checks++;
        if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_cnt: hit/miss got %0d/%0d exp 0/0", hit_cnt_o, miss_cnt_o);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [127:0] l;
        l = {32'h4, 32'h3, 32'h2, 32'h1};
        do_reset();
        fetch(32'h8000_0000, 3, 99, l);
        if_req_i = 1'b1; if_addr_i = 32'h8000_0008;
        #1;
        checks++;
        if (if_ack_o !== 1'b1 || if_rdata_o !== 32'h3) begin
            errors++;
            $display("FAIL basic_hit: ack/rdata got %b/%h exp 1/00000003", if_ack_o, if_rdata_o);
        end
        n_hit++;
        @(negedge clk);
        if_req_i = 1'b0;
        fetch(32'h8000_0004, 0, 99, l);
        fetch(32'h8000_000C, 0, 99, l);
    endtask

    task automatic test_evict();
        fetch(32'h8000_0400, 2, 99, mk_line(32'h8000_0400));
        fetch(32'h8000_0000, 1, 99, mk_line(32'h8000_0000));
        fetch(32'h8000_0404, 0, 99, mk_line(32'h8000_0400));
        fetch(32'h8000_0000, 0, 99, mk_line(32'h8000_0000));
    endtask

    task automatic test_kill();
        logic [31:0] a, b;
        a = 32'h8000_0010; b = 32'h8000_0020;
        do_reset();
        fetch(b, 1, 99, mk_line(b));
        if_req_i = 1'b1; if_addr_i = a;
        #1;
        checks++;
        if (if_ack_o !== 1'b0) begin errors++; $display("FAIL kill_miss: ack got %b exp 0", if_ack_o); end
        n_miss++;
        @(negedge clk);
        if_req_i = 1'b0; if_kill_i = 1'b1;
        @(negedge clk);
        if_kill_i = 1'b0; if_req_i = 1'b1; if_addr_i = b;
        #1;
        checks++;
        if (if_ack_o !== 1'b0 || mem_req_o !== 1'b1) begin
            errors++;
            $display("FAIL killed_wait: ack/req got %b/%b exp 0/1", if_ack_o, mem_req_o);
        end
        @(negedge clk);
        if_req_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = mk_line(a);
        #1;
        checks++;
        if (mem_req_o !== 1'b1) begin errors++; $display("FAIL killed_hold: req got %b exp 1", mem_req_o); end
        @(negedge clk);
        mem_ack_i = 1'b0;
        #1;
        checks++;
        if (mem_req_o !== 1'b0) begin errors++; $display("FAIL killed_drop: req got %b exp 0", mem_req_o); end
        @(negedge clk);
        fetch(a, 0, 99, mk_line(a));
        fetch(b, 0, 99, mk_line(b));
        fetch(32'h8000_0030, 2, 2, mk_line(32'h8000_0030));
        fetch(32'h8000_0034, 0, 99, mk_line(32'h8000_0030));
    endtask

    task automatic test_flush();
        logic [31:0] a1, a2;
        a1 = 32'h8000_03F0; a2 = 32'h8000_0200;
        do_reset();
        fetch(a1, 0, 99, mk_line(a1));
        fetch(a2, 1, 99, mk_line(a2));
        if_flush_i = 1'b1; if_req_i = 1'b1; if_addr_i = a1;
        #1;
        checks++;
        if (if_ack_o !== 1'b0) begin errors++; $display("FAIL flush_prio: ack got %b exp 0", if_ack_o); end
        @(negedge clk);
        // Re-asserted flush at step 20 restarts the sweep: 21 + 64 blocked cycles in total.
        for (int i = 0; i < 85; i++) begin
            if_flush_i = (i == 20); if_addr_i = i[0] ? a1 : a2; mem_ack_i = (i == 7);
            mem_rdata_i = mk_line(a1);
            #1;
            checks++;
            if (if_ack_o !== 1'b0 || mem_req_o !== 1'b0) begin
                errors++;
                $display("FAIL flush_cyc %0d: ack/req got %b/%b exp 0/0", i, if_ack_o, mem_req_o);
            end
            @(negedge clk);
        end
        if_flush_i = 1'b0; if_req_i = 1'b0; mem_ack_i = 1'b0;
        model_clear();
        fetch(a1, 0, 99, mk_line(a1));
        fetch(a2, 0, 99, mk_line(a2));
    endtask

    task automatic test_flush_in_miss();
        logic [31:0] a1, a2;
        a1 = 32'h8000_0050; a2 = 32'h8000_0FF0;
        do_reset();
        fetch(a2, 0, 99, mk_line(a2));
        if_req_i = 1'b1; if_addr_i = a1;
        n_miss++;
        @(negedge clk);
        if_req_i = 1'b0;
        @(negedge clk);
        if_flush_i = 1'b1;
        @(negedge clk);
        if_flush_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = mk_line(a1);
        @(negedge clk);
        mem_ack_i = 1'b0; if_req_i = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if_addr_i = i[0] ? a1 : a2;
            #1;
            checks++;
            if (if_ack_o !== 1'b0 || mem_req_o !== 1'b0) begin
                errors++;
                $display("FAIL fmiss_cyc %0d: ack/req got %b/%b exp 0/0", i, if_ack_o, mem_req_o);
            end
            @(negedge clk);
        end
        if_req_i = 1'b0;
        model_clear();
        fetch(a1, 1, 99, mk_line(a1));
        fetch(a2, 0, 99, mk_line(a2));
    endtask

    task automatic test_rst_miss();
        logic [31:0] a;
        a = 32'h8000_0070;
        fetch(a, 0, 99, mk_line(a));
        if_req_i = 1'b1; if_addr_i = 32'h8000_1070;
        @(negedge clk);
        if_req_i = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear(); n_hit = 0; n_miss = 0;
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_miss: req/addr got %b/%h exp 0/0", mem_req_o, mem_addr_o);
        end
`ifdef ICACHE_PERF_CNT_EN
        checks++;
        if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin
            errors++;
            $display("FAIL rst_cnt: hit/miss got %0d/%0d exp 0/0", hit_cnt_o, miss_cnt_o);
        end
`endif
        @(negedge clk);
        mem_ack_i = 1'b1; mem_rdata_i = mk_line(32'h8000_1070);
        #1;
        checks++;
        if (if_ack_o !== 1'b0) begin errors++; $display("FAIL stray_ack: ack got %b exp 0", if_ack_o); end
        @(negedge clk);
        mem_ack_i = 1'b0;
        fetch(32'h8000_1070, 0, 99, mk_line(32'h8000_1070));
        fetch(a, 0, 99, mk_line(a));
    endtask

    task automatic test_random();
        logic [31:0] a;
        int lat, killat;
        do_reset();
        for (int n = 0; n < 120; n++) begin
            a = 32'h8000_0000 + 32'($urandom_range(0, 2)) * 1024
                + 32'($urandom_range(0, 3) * 21) * 16 + 32'($urandom_range(0, 3)) * 4;
            lat = $urandom_range(0, 3);
            killat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lat) : 99;
            fetch(a, lat, killat, mk_line(a & ~32'hF));
        end
`ifdef ICACHE_PERF_CNT_EN
        checks++;
        if (hit_cnt_o !== 32'(n_hit) || miss_cnt_o !== 32'(n_miss)) begin
            errors++;
            $display("FAIL perf_cnt: hit/miss got %0d/%0d exp %0d/%0d", hit_cnt_o, miss_cnt_o, n_hit, n_miss);
        end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; if_req_i = 0; if_kill_i = 0; if_flush_i = 0; mem_ack_i = 0;
        if_addr_i = 0; mem_rdata_i = '0;
        test_reset();
        test_basic();
        test_evict();
        test_kill();
        test_flush();
        test_flush_in_miss();
        test_rst_miss();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
